// File: rtl/rv_plic_reg_pkg.sv
`default_nettype none
// ==========================================================================
// rv_plic_reg_pkg: PLIC register-level constants shared across the PLIC blocks
// Rev 1.0
// ==========================================================================
package rv_plic_reg_pkg;

    parameter int NumSrc = 32;

    typedef logic [NumSrc-1:0] src_vec_t;

endpackage : rv_plic_reg_pkg
`default_nettype wire

// File: rtl/prim_flop_2sync.sv
`default_nettype none
// ==========================================================================
// prim_flop_2sync: two-stage flop synchronizer for asynchronous inputs
// Rev 1.0
// ==========================================================================
module prim_flop_2sync #(
    parameter int               Width      = 16,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] s1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1  <= ResetValue;
            q_o <= ResetValue;
        end else begin
            s1  <= d_i;
            q_o <= s1;
        end
    end

endmodule : prim_flop_2sync
`default_nettype wire

// File: rtl/rv_plic_src_filter.sv
`default_nettype none
// ==========================================================================
// rv_plic_src_filter: one source slice - sync, polarity, debounce, rise pulse
// Rev 1.0
// ==========================================================================
module rv_plic_src_filter #(
    parameter int CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            raw_i,
    input  logic            pol_i,
    input  logic            filt_en_i,
    input  logic [CntW-1:0] filt_thresh_i,
    output logic            src_o,
    output logic            rise_o
);

    logic            s2;
    logic            cond;
    logic            q;
    logic            q_nxt;
    logic            rise;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (raw_i),
        .q_o    (s2)
    );

    assign cond = s2 ^ pol_i;

    // cnt only advances while below the threshold, so it can never wrap;
    // ">=" lets a lowered threshold commit a pending change immediately.
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        if (!filt_en_i) begin
            q_nxt   = cond;
            cnt_nxt = '0;
        end else if (cond == q) begin
            cnt_nxt = '0;
        end else if (cnt >= filt_thresh_i) begin
            q_nxt   = cond;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q    <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            rise <= q_nxt & ~q;
        end
    end

    assign src_o  = q;
    assign rise_o = rise;

endmodule : rv_plic_src_filter
`default_nettype wire

// File: rtl/rv_plic_src_cond.sv
`default_nettype none
// ==========================================================================
// rv_plic_src_cond: per-source interrupt conditioning in front of the PLIC
// Rev 1.0
// ==========================================================================
module rv_plic_src_cond #(
    parameter int NumSrc = rv_plic_reg_pkg::NumSrc,
    parameter int CntW   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] intr_raw_i,
    input  logic [NumSrc-1:0] pol_i,
    input  logic [NumSrc-1:0] filt_en_i,
    input  logic [CntW-1:0]   filt_thresh_i,
    output logic [NumSrc-1:0] intr_src_o,
    output logic [NumSrc-1:0] intr_rise_o
);

    // PLIC ID 0 is reserved: no logic behind it, inputs are deliberately dropped.
    logic unused_src0;
    assign unused_src0    = ^{intr_raw_i[0], pol_i[0], filt_en_i[0]};
    assign intr_src_o[0]  = 1'b0;
    assign intr_rise_o[0] = 1'b0;

    for (genvar s = 1; s < NumSrc; s++) begin : g_src
        rv_plic_src_filter #(
            .CntW (CntW)
        ) u_filter (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .raw_i         (intr_raw_i[s]),
            .pol_i         (pol_i[s]),
            .filt_en_i     (filt_en_i[s]),
            .filt_thresh_i (filt_thresh_i),
            .src_o         (intr_src_o[s]),
            .rise_o        (intr_rise_o[s])
        );
    end

endmodule : rv_plic_src_cond
`default_nettype wire

// File: tb/tb_rv_plic_src_cond.sv
`default_nettype none
// ==========================================================================
// tb_rv_plic_src_cond: scoreboard bench with reference model and random traffic
// Rev 1.0
// ==========================================================================
module tb_rv_plic_src_cond;

    localparam int NS = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] raw;
    logic [NS-1:0] pol;
    logic [NS-1:0] en;
    logic [CW-1:0] thr;
    logic [NS-1:0] src;
    logic [NS-1:0] rise;

    int n_cmp = 0;
    int n_bad = 0;

    rv_plic_src_cond #(
        .NumSrc (NS),
        .CntW   (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .intr_raw_i    (raw),
        .pol_i         (pol),
        .filt_en_i     (en),
        .filt_thresh_i (thr),
        .intr_src_o    (src),
        .intr_rise_o   (rise)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: raw is seen two edges late; a level difference is
    // accepted once it has been observed on more than thr consecutive edges.
    typedef struct {
        logic [NS-1:0] q;
        logic [NS-1:0] rise;
    } exp_t;

    exp_t          expq[$];
    logic [NS-1:0] seen1, seen2, m_q, m_rise;
    int            age[NS];

    always @(posedge clk) begin
        exp_t e;
        logic c, nq;
        if (!rst_n) begin
            seen1  = '0;
            seen2  = '0;
            m_q    = '0;
            m_rise = '0;
            for (int s = 0; s < NS; s++) age[s] = 0;
        end else begin
            for (int s = 1; s < NS; s++) begin
                c  = seen2[s] ^ pol[s];
                nq = m_q[s];
                if (!en[s] || c == m_q[s]) begin
                    if (!en[s]) nq = c;
                    age[s] = 0;
                end else if (age[s] >= int'(thr)) begin
                    nq = c;
                    age[s] = 0;
                end else begin
                    age[s]++;
                end
                m_rise[s] = nq & ~m_q[s];
                m_q[s]    = nq;
            end
            seen2 = seen1;
            seen1 = raw;
        end
        e.q    = m_q;
        e.rise = m_rise;
        e.q[0]    = 1'b0;
        e.rise[0] = 1'b0;
        expq.push_back(e);
    end

    // Monitor: one expected entry per clock, compared mid high phase.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                e = expq.pop_front();
                n_cmp++;
                if (src !== e.q) begin
                    n_bad++;
                    $display("FAIL sb_src @%0t: got %h expected %h", $time, src, e.q);
                end
                n_cmp++;
                if (rise !== e.rise) begin
                    n_bad++;
                    $display("FAIL sb_rise @%0t: got %h expected %h", $time, rise, e.rise);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic quiesce();
        @(negedge clk);
        raw = '0;
        pol = '0;
        en  = '0;
        thr = '0;
        edges(5);
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = '0;
        pol   = '0;
        en    = '0;
        thr   = '0;
        edges(1);
        chk("reset_src", src, '0);
        chk("reset_rise", rise, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edges(3);

        // V1: unfiltered, three-edge latency, single rise pulse
        @(negedge clk);
        raw[3] = 1'b1;
        edges(2);
        chk("v1_src_e2", NS'(src[3]), NS'(0));
        edges(1);
        chk("v1_src_e3", NS'(src[3]), NS'(1));
        chk("v1_rise_e3", NS'(rise[3]), NS'(1));
        edges(1);
        chk("v1_rise_e4", NS'(rise[3]), NS'(0));
        chk("v1_src_e4", NS'(src[3]), NS'(1));
        quiesce();

        // V2: 4-cycle glitch rejected, 5-cycle pulse accepted after 3+4 edges
        @(negedge clk);
        en[5] = 1'b1;
        thr   = 8'd4;
        edges(2);
        @(negedge clk);
        raw[5] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edges(1);
            chk("v2_glitch_held", NS'(src[5]), NS'(0));
            if (k == 4) raw[5] = 1'b0;
        end
        @(negedge clk);
        raw[5] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            if (k == 5) raw[5] = 1'b0;
            if (k == 6) chk("v2_src_e6", NS'(src[5]), NS'(0));
            if (k == 7) begin
                chk("v2_src_e7", NS'(src[5]), NS'(1));
                chk("v2_rise_e7", NS'(rise[5]), NS'(1));
            end
        end
        quiesce();

        // V3: active-low source, unfiltered
        @(negedge clk);
        pol[7] = 1'b1;
        raw[7] = 1'b1;
        edges(5);
        chk("v3_idle", NS'(src[7]), NS'(0));
        @(negedge clk);
        raw[7] = 1'b0;
        edges(3);
        chk("v3_src_on", NS'(src[7]), NS'(1));
        chk("v3_rise_on", NS'(rise[7]), NS'(1));
        edges(2);
        @(negedge clk);
        raw[7] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edges(1);
            chk("v3_no_rise_on_fall", NS'(rise[7]), NS'(0));
            if (k == 3) chk("v3_src_off", NS'(src[7]), NS'(0));
        end
        quiesce();

        // V4: lowering the threshold below a running count commits next edge
        @(negedge clk);
        en[9] = 1'b1;
        thr   = 8'd200;
        edges(2);
        @(negedge clk);
        raw[9] = 1'b1;
        edges(52);
        chk("v4_pending", NS'(src[9]), NS'(0));
        @(negedge clk);
        thr = 8'd10;
        edges(1);
        chk("v4_commit", NS'(src[9]), NS'(1));
        chk("v4_commit_rise", NS'(rise[9]), NS'(1));

        // V5: reset mid-count discards progress; re-qualify after 3+4 edges
        @(negedge clk);
        en[2] = 1'b1;
        thr   = 8'd4;
        raw[2] = 1'b1;
        edges(5);
        chk("v5_counting", NS'(src[2]), NS'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("v5_reset_src", src, '0);
        chk("v5_reset_rise", rise, '0);
        @(negedge clk);
        rst_n = 1'b1;
        edges(6);
        chk("v5_src_e6", NS'(src[2]), NS'(0));
        edges(1);
        chk("v5_src_e7", NS'(src[2]), NS'(1));
        quiesce();

        // Random traffic; raw[0] toggles freely and must never show up.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int s = 1; s < NS; s++)
                if ($urandom_range(0, 7) == 0) raw[s] = ~raw[s];
            raw[0] = 1'($urandom());
            if ($urandom_range(0, 63) == 0) thr = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) en = NS'($urandom());
            if ($urandom_range(0, 199) == 0) pol[$urandom_range(1, NS - 1)] ^= 1'b1;
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edges(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rv_plic_src_cond
`default_nettype wire
